hsv_compute: RTL



---
 rtl/hsv_compute_pkg.sv | 59 +++++
 rtl/div16_serial.sv | 80 ++++++++
 rtl/hsv_compute.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/hsv_compute_pkg.sv
// Shared constants, FSM state type and channel-select helpers for hsv_compute.
package hsv_compute_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DIV_W  = 16;

    localparam int HUE_R_BASE = 0;
    localparam int HUE_G_BASE = 120;
    localparam int HUE_B_BASE = 240;
    localparam int HUE_WRAP   = 360;
    localparam int HUE_SCALE  = 60;
    localparam int SAT_SCALE  = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV_H = 2'd1,
        DIV_S = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SEL_R = 2'd0,
        SEL_G = 2'd1,
        SEL_B = 2'd2
    } chan_e;

    // Which channel holds the maximum; ties resolve R, then G, then B.
    function automatic chan_e max_chan(input logic signed [DATA_W-1:0] r_g,
                                       input logic signed [DATA_W-1:0] g_b,
                                       input logic signed [DATA_W-1:0] b_r);
        if (r_g >= 0 && b_r <= 0) begin
            return SEL_R;
        end else if (r_g <= 0 && g_b >= 0) begin
            return SEL_G;
        end
        return SEL_B;
    endfunction

    // Signed hue numerator for the selected channel.
    function automatic logic signed [DATA_W-1:0] hue_num(input chan_e c,
                                                        input logic signed [DATA_W-1:0] r_g,
                                                        input logic signed [DATA_W-1:0] g_b,
                                                        input logic signed [DATA_W-1:0] b_r);
        case (c)
            SEL_R:   return HUE_SCALE * g_b;
            SEL_G:   return HUE_SCALE * b_r;
            default: return HUE_SCALE * r_g;
        endcase
    endfunction

    function automatic logic signed [DATA_W-1:0] hue_base(input chan_e c);
        case (c)
            SEL_R:   return HUE_R_BASE;
            SEL_G:   return HUE_G_BASE;
            default: return HUE_B_BASE;
        endcase
    endfunction

endpackage

// File: rtl/div16_serial.sv
// 16-bit unsigned restoring divider, one quotient bit per clock.
// The start edge already performs the first iteration, so the quotient is final
// 16 edges after start and done pulses for one cycle right after that.
module div16_serial
    import hsv_compute_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    logic [DIV_W-1:0] rem_q;
    logic [DIV_W-1:0] dq_q;   // dividend shifts out at the top, quotient shifts in at the bottom
    logic [DIV_W-1:0] dvs_q;
    logic [4:0]       cnt_q;
    logic             busy_q;
    logic             done_q;

    logic [DIV_W-1:0] src_rem;
    logic [DIV_W-1:0] src_dq;
    logic [DIV_W-1:0] src_dvs;
    logic [DIV_W:0]   trial;
    logic [DIV_W:0]   rem_step;
    logic [DIV_W-1:0] dq_step;
    logic             fits;
    logic             unused_rem_msb;

    // One restoring step, fed from the new operands on start, else from state.
    always_comb begin
        src_rem  = start ? '0 : rem_q;
        src_dq   = start ? dividend : dq_q;
        src_dvs  = start ? divisor : dvs_q;
        trial    = {src_rem, src_dq[DIV_W-1]};
        fits     = trial >= {1'b0, src_dvs};
        rem_step = fits ? (trial - {1'b0, src_dvs}) : trial;
        dq_step  = {src_dq[DIV_W-2:0], fits};
    end

    // Remainder is always below the divisor, so its top bit is always zero.
    assign unused_rem_msb = rem_step[DIV_W];

    // Iteration counter and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            dq_q   <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q  <= rem_step[DIV_W-1:0];
                dq_q   <= dq_step;
                dvs_q  <= divisor;
                cnt_q  <= 5'(DIV_W - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= rem_step[DIV_W-1:0];
                dq_q  <= dq_step;
                cnt_q <= cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = dq_q;

endmodule

// File: rtl/hsv_compute.sv
// RGB-derived operands to HSV: hue and saturation via one shared serial divider.
// Result appears 32 clocks after acceptance and is held until out_ready.
module hsv_compute
    import hsv_compute_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] max,
    input  logic [DATA_W-1:0] min,
    input  logic [DATA_W-1:0] R_G,
    input  logic [DATA_W-1:0] G_B,
    input  logic [DATA_W-1:0] B_R,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] hue,
    output logic [DATA_W-1:0] sat,
    output logic [DATA_W-1:0] val
);

    state_e state_q, state_d;

    logic [DATA_W-1:0] max_q;
    logic [DATA_W-1:0] delta_q;
    chan_e             sel_q;
    logic              neg_q;
    logic [DATA_W-1:0] hue_res_q;
    logic [DATA_W-1:0] hue_q, sat_q, val_q;

    chan_e                    in_sel;
    logic signed [DATA_W-1:0] in_num;
    logic [DATA_W-1:0]        in_abs;
    logic [DATA_W-1:0]        in_delta;
    logic [DATA_W-1:0]        sat_num;
    logic signed [DATA_W-1:0] hue_raw;
    logic [DATA_W-1:0]        hue_calc;
    logic [DATA_W-1:0]        sat_calc;
    logic                     accept;

    logic             div_start;
    logic [DIV_W-1:0] div_dvd;
    logic [DIV_W-1:0] div_dvs;
    logic             div_busy;
    logic             div_done;
    logic [DIV_W-1:0] div_quot;
    logic             unused_bits;

    // Operand preparation: hue division is launched straight from the inputs on accept.
    always_comb begin
        in_sel    = max_chan(R_G, G_B, B_R);
        in_num    = hue_num(in_sel, R_G, G_B, B_R);
        in_abs    = (in_num < 0) ? DATA_W'(-in_num) : DATA_W'(in_num);
        in_delta  = max - min;
        sat_num   = delta_q * DATA_W'(SAT_SCALE);
        accept    = (state_q == IDLE) && in_valid;
        div_start = accept || ((state_q == DIV_H) && div_done);
        div_dvd   = (state_q == IDLE) ? in_abs[DIV_W-1:0] : sat_num[DIV_W-1:0];
        div_dvs   = (state_q == IDLE) ? in_delta[DIV_W-1:0] : max_q[DIV_W-1:0];
    end

    // Operands fit in 16 bits for 8-bit channels; upper bits are never significant.
    assign unused_bits = ^{in_abs[DATA_W-1:DIV_W], sat_num[DATA_W-1:DIV_W], div_busy};

    // Hue and saturation from the divider quotient, with degenerate-colour overrides.
    always_comb begin
        hue_raw = neg_q ? (hue_base(sel_q) - DATA_W'(div_quot))
                        : (hue_base(sel_q) + DATA_W'(div_quot));
        if (delta_q == '0) begin
            hue_calc = '0;
        end else if (hue_raw < 0) begin
            hue_calc = DATA_W'(hue_raw + HUE_WRAP);
        end else begin
            hue_calc = DATA_W'(hue_raw);
        end
        sat_calc = (delta_q == '0 || max_q == '0) ? '0 : DATA_W'(div_quot);
    end

    // Control FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = DIV_H;
            DIV_H:   if (div_done)  state_d = DIV_S;
            DIV_S:   if (div_done)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, captured operands and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            max_q     <= '0;
            delta_q   <= '0;
            sel_q     <= SEL_R;
            neg_q     <= 1'b0;
            hue_res_q <= '0;
            hue_q     <= '0;
            sat_q     <= '0;
            val_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                max_q   <= max;
                delta_q <= in_delta;
                sel_q   <= in_sel;
                neg_q   <= in_num < 0;
            end
            if (state_q == DIV_H && div_done) begin
                hue_res_q <= hue_calc;
            end
            // Outputs only change on entry to DONE so no partial result is ever visible.
            if (state_q == DIV_S && div_done) begin
                hue_q <= hue_res_q;
                sat_q <= sat_calc;
                val_q <= max_q;
            end
        end
    end

    div16_serial u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dvd),
        .divisor  (div_dvs),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign hue       = hue_q;
    assign sat       = sat_q;
    assign val       = val_q;

endmodule
